// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its two-requester sharing controller.
// Opcode encodings and the sharing FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1110;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_LUI = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } share_state_e;

endpackage

// File: rtl/alu.sv
// Combinational alu: result is exactly DATA_WIDTH bits, undefined opcodes give 0.
// LUI passes SrcB through (immediate arrives pre-shifted).
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    always_comb begin
        ALUResult = '0;
        case (Operation)
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_XOR: ALUResult = SrcA ^ SrcB;
            ALU_SRL: ALUResult = SrcA >> SrcB;
            ALU_SLL: ALUResult = SrcA << SrcB;
            ALU_SLT: ALUResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_EQ:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            ALU_LUI: ALUResult = SrcB;
            default: ALUResult = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one alu between two requesters with round-robin arbitration, one op in flight.
// Define ALU_SHARE_PERF_EN to add per-requester grant counters.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_WIDTH-1:0]    rsp_result,
    output logic                     busy
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [31:0]              grant_cnt0,
    output logic [31:0]              grant_cnt1
`endif
);

    share_state_e             state, state_next;
    logic                     rr_ptr;
    logic                     winner;
    logic                     grant;
    logic [DATA_WIDTH-1:0]    srca_q, srcb_q, alu_result;
    logic [OPCODE_LENGTH-1:0] op_q;

    // Contention goes to rr_ptr; otherwise whichever side is valid.
    assign winner = (req0_valid && req1_valid) ? rr_ptr : req1_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant      = 1'b1;
                    req0_ready = !winner;
                    req1_ready = winner;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            srca_q     <= '0;
            srcb_q     <= '0;
            op_q       <= '0;
            rsp_id     <= 1'b0;
            rr_ptr     <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (grant) begin
                srca_q <= winner ? req1_srca : req0_srca;
                srcb_q <= winner ? req1_srcb : req0_srcb;
                op_q   <= winner ? req1_op : req0_op;
                rsp_id <= winner;
                rr_ptr <= !winner;
            end
            if (state == EXEC) rsp_result <= alu_result;
        end
    end

    alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_LENGTH(OPCODE_LENGTH)
    ) u_alu (
        .SrcA     (srca_q),
        .SrcB     (srcb_q),
        .Operation(op_q),
        .ALUResult(alu_result)
    );

`ifdef ALU_SHARE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant) begin
            if (winner) grant_cnt1 <= grant_cnt1 + 32'd1;
            else        grant_cnt0 <= grant_cnt0 + 32'd1;
        end
    end
`endif

endmodule
